// File: rtl/nios_spi_tx_fifo.sv
// Avalon-MM transmit FIFO feeding the SPI shifter.
// Show-ahead queue with status/level, threshold IRQ, flush.
module nios_spi_tx_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  irq
);

   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam int LW    = DEPTH_LOG2 + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [LW-1:0]         level;
   logic                  overflow;
   logic                  irq_en;
   logic [7:0]            threshold;

   logic        wr;
   logic        full;
   logic        empty;
   logic        push;
   logic        pop;
   logic        flush;
   logic        ovf_set;
   logic        ovf_clr;
   logic [7:0]  level8;
   logic [31:0] rd_next;
   logic        unused_wdata;

   assign unused_wdata = &{1'b0, writedata};

   assign wr      = chipselect & ~write_n;
   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign push    = wr & (address == 2'd0) & ~full;
   assign ovf_set = wr & (address == 2'd0) & full;
   assign pop     = tx_valid & tx_ready;
   assign flush   = wr & (address == 2'd1) & writedata[8];
   assign ovf_clr = wr & (address == 2'd1) & writedata[2];
   assign level8  = 8'(level);

   assign tx_valid = ~empty;
   assign tx_data  = tx_valid ? mem[rd_ptr] : '0;

   // Storage array; contents are don't-care until pushed.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= writedata[DATA_WIDTH-1:0];
   end

   // Pointers and level; flush overrides a same-cycle pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push & ~pop)      level <= level + 1'b1;
         else if (pop & ~push) level <= level - 1'b1;
      end
   end

   // Sticky overflow (a new event beats a clear) and CONTROL.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow  <= 1'b0;
         irq_en    <= 1'b0;
         threshold <= '0;
      end else begin
         if (ovf_set)      overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
         if (wr & (address == 2'd2)) begin
            irq_en    <= writedata[0];
            threshold <= writedata[15:8];
         end
      end
   end

   // Read mux from current address; no side effects.
   always_comb begin
      rd_next = '0;
      case (address)
         2'd0:    rd_next = 32'(tx_data);
         2'd1:    rd_next = {16'd0, level8, 5'd0,
                             overflow, full, empty};
         2'd2:    rd_next = {16'd0, threshold, 7'd0, irq_en};
         default: rd_next = '0;
      endcase
   end

   // Registered readdata and refill interrupt.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readdata <= '0;
         irq      <= 1'b0;
      end else begin
         readdata <= rd_next;
         irq      <= irq_en & (level8 <= threshold);
      end
   end

endmodule

// File: tb/tb_nios_spi_tx_fifo.sv
// Bench for nios_spi_tx_fifo: directed scenarios plus
// random traffic against a queue-based reference model.
module tb_nios_spi_tx_fifo;

   logic        clk;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [15:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        irq;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] q[$];
   bit          m_ovf;
   bit          m_ien;
   int          m_thr;
   logic [31:0] exp_rd;
   bit          exp_irq;

   nios_spi_tx_fifo #(.DATA_WIDTH(16), .DEPTH_LOG2(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf = 0;
      m_ien = 0;
      m_thr = 0;
   endtask

   // One clock: model reacts to the pre-edge state and inputs,
   // then DUT outputs are compared just after the edge.
   task automatic step();
      bit wr;
      int lvl;
      wr  = chipselect && !write_n;
      lvl = q.size();
      case (address)
         2'd0: exp_rd = (lvl > 0) ? {16'd0, q[0]} : 32'd0;
         2'd1: exp_rd = (lvl << 8) | (32'(m_ovf) << 2)
                      | (32'(lvl == 8) << 1) | 32'(lvl == 0);
         2'd2: exp_rd = (m_thr << 8) | 32'(m_ien);
         default: exp_rd = 32'd0;
      endcase
      exp_irq = m_ien && (lvl <= m_thr);
      if (wr && address == 2'd1 && writedata[8]) begin
         q.delete();
      end else begin
         if (lvl > 0 && tx_ready) void'(q.pop_front());
         if (wr && address == 2'd0 && lvl < 8)
            q.push_back(writedata[15:0]);
      end
      if (wr && address == 2'd0 && lvl == 8) m_ovf = 1;
      else if (wr && address == 2'd1 && writedata[2]) m_ovf = 0;
      if (wr && address == 2'd2) begin
         m_ien = writedata[0];
         m_thr = int'(writedata[15:8]);
      end
      @(posedge clk);
      #1;
      check("readdata", readdata, exp_rd);
      check("irq", 32'(irq), 32'(exp_irq));
      check("tx_valid", 32'(tx_valid), 32'(q.size() > 0));
      check("tx_data", 32'(tx_data),
            (q.size() > 0) ? 32'(q[0]) : 32'd0);
   endtask

   task automatic bus(input logic c, input logic w,
                      input logic [1:0] a, input logic [31:0] d,
                      input logic r);
      chipselect = c;
      write_n    = w;
      address    = a;
      writedata  = d;
      tx_ready   = r;
      step();
   endtask

   task automatic idle(input logic r);
      bus(1'b0, 1'b1, 2'd0, 32'd0, r);
   endtask

   task automatic push(input logic [15:0] w, input logic r);
      bus(1'b1, 1'b0, 2'd0, {16'd0, w}, r);
   endtask

   task automatic rd_status();
      bus(1'b1, 1'b1, 2'd1, 32'd0, 1'b0);
   endtask

   initial begin
      reset      = 1'b1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 2'd0;
      writedata  = 32'd0;
      tx_ready   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_readdata", readdata, 32'd0);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      reset = 1'b0;

      rd_status();
      check("t1_status", readdata, 32'h1);

      push(16'hA5A5, 1'b0);
      check("t2_head", 32'(tx_data), 32'hA5A5);
      push(16'h1234, 1'b0);
      push(16'hBEEF, 1'b0);
      rd_status();
      check("t2_level3", readdata, 32'h300);
      repeat (3) idle(1'b1);
      rd_status();
      check("t2_empty", readdata, 32'h1);

      for (int i = 0; i < 8; i++) push(16'($urandom), 1'b0);
      push(16'hDEAD, 1'b0);
      rd_status();
      check("t3_full_ovf", readdata, 32'h806);
      bus(1'b1, 1'b0, 2'd1, 32'h4, 1'b0);
      rd_status();
      check("t3_ovf_clr", readdata, 32'h802);

      push(16'hDEAD, 1'b1);
      rd_status();
      check("t4_pop_drop", readdata, 32'h704);
      repeat (3) idle(1'b1);
      push(16'h4444, 1'b1);
      rd_status();
      check("t4_pushpop", readdata, 32'h404);

      bus(1'b1, 1'b0, 2'd1, 32'h4, 1'b0);
      bus(1'b1, 1'b0, 2'd2, 32'h0201, 1'b1);
      idle(1'b0);
      check("t5_irq_lvl3", 32'(irq), 32'd0);
      idle(1'b1);
      idle(1'b0);
      check("t5_irq_lvl2", 32'(irq), 32'd1);
      bus(1'b1, 1'b0, 2'd2, 32'h0200, 1'b0);
      idle(1'b0);
      check("t5_irq_off", 32'(irq), 32'd0);

      repeat (3) push(16'($urandom), 1'b0);
      bus(1'b1, 1'b0, 2'd1, 32'h100, 1'b1);
      check("t6_flush_valid", 32'(tx_valid), 32'd0);
      rd_status();
      check("t6_flush_status", readdata, 32'h1);

      for (int i = 0; i < 3000; i++) begin
         logic [31:0] d;
         logic [1:0]  a;
         d = $urandom;
         a = 2'($urandom_range(0, 3));
         if (a == 2'd1 && $urandom_range(0, 7) != 0) d[8] = 1'b0;
         if (a == 2'd2) d[15:8] = 8'($urandom_range(0, 9));
         bus(1'($urandom_range(0, 1)),
             ($urandom_range(0, 2) == 0), a, d,
             1'($urandom_range(0, 2) == 0));
      end

      bus(1'b1, 1'b0, 2'd2, 32'h0801, 1'b0);
      repeat (3) push(16'($urandom), 1'b0);
      idle(1'b0);
      #2;
      reset = 1'b1;
      #1;
      check("t6_async_valid", 32'(tx_valid), 32'd0);
      check("t6_async_data", 32'(tx_data), 32'd0);
      check("t6_async_irq", 32'(irq), 32'd0);
      check("t6_async_rd", readdata, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      rd_status();
      check("t6_post_rst", readdata, 32'h1);
      push(16'h5A5A, 1'b0);
      idle(1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
